// File: rtl/bank_readout_sequencer_if.sv
// -----------------------------------------------------------------------------
// bank_readout_sequencer_if : read-mux and output-stream bundle of the sequencer
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface bank_readout_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_BANKS  = 4
);
   localparam int SELW = $clog2(NUM_BANKS);

   logic                  start;
   logic                  busy;
   logic                  done;
   logic [SELW-1:0]       rd_sel;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic [SELW-1:0]       out_bank;
   logic                  out_valid;
   logic                  out_ready;

   // master: the sequencer; slave: the byte store plus downstream consumer
   modport master (
      input  start, rd_data, out_ready,
      output busy, done, rd_sel, out_data, out_bank, out_valid
   );

   modport slave (
      output start, rd_data, out_ready,
      input  busy, done, rd_sel, out_data, out_bank, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/bank_readout_sequencer.sv
// -----------------------------------------------------------------------------
// bank_readout_sequencer : sweeps bank select, captures each byte, streams it out.
// Optional READOUT_CHECKSUM_EN appends an XOR checksum word to every sweep.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module bank_readout_sequencer #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_BANKS     = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   bank_readout_sequencer_if.master bus
);
   localparam int SELW = $clog2(NUM_BANKS);
   localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_PRESENT = 2'd3;

   localparam logic [SELW-1:0] LAST_BANK = SELW'(NUM_BANKS - 1);
   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(SETTLE_CYCLES - 1);

   logic [1:0]            state_q,     state_d;
   logic [CNTW-1:0]       cnt_q,       cnt_d;
   logic [SELW-1:0]       rd_sel_q,    rd_sel_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]       out_bank_q,  out_bank_d;
   logic                  out_valid_q, out_valid_d;
   logic                  done_q,      done_d;
   logic                  accept;

`ifdef READOUT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_q,       xor_d;
   logic                  csum_q,      csum_d;
`endif

   assign accept = out_valid_q && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_sel_d    = rd_sel_q;
      out_data_d  = out_data_q;
      out_bank_d  = out_bank_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
`ifdef READOUT_CHECKSUM_EN
      xor_d       = xor_q;
      csum_d      = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_SETTLE;
               rd_sel_d = '0;
               cnt_d    = '0;
`ifdef READOUT_CHECKSUM_EN
               xor_d    = '0;
               csum_d   = 1'b0;
`endif
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            out_data_d  = bus.rd_data;
            out_bank_d  = rd_sel_q;
            out_valid_d = 1'b1;
            state_d     = ST_PRESENT;
`ifdef READOUT_CHECKSUM_EN
            xor_d       = xor_q ^ bus.rd_data;
`endif
         end
         ST_PRESENT: begin
            if (accept) begin
               out_valid_d = 1'b0;
`ifdef READOUT_CHECKSUM_EN
               // The checksum word is presented straight after the last bank is
               // accepted, without another settle pass.
               if (csum_q) begin
                  state_d  = ST_IDLE;
                  done_d   = 1'b1;
                  rd_sel_d = '0;
                  csum_d   = 1'b0;
               end else if (rd_sel_q == LAST_BANK) begin
                  out_data_d  = xor_q;
                  out_bank_d  = '0;
                  out_valid_d = 1'b1;
                  csum_d      = 1'b1;
               end else begin
                  state_d  = ST_SETTLE;
                  rd_sel_d = rd_sel_q + 1'b1;
                  cnt_d    = '0;
               end
`else
               if (rd_sel_q == LAST_BANK) begin
                  state_d  = ST_IDLE;
                  done_d   = 1'b1;
                  rd_sel_d = '0;
               end else begin
                  state_d  = ST_SETTLE;
                  rd_sel_d = rd_sel_q + 1'b1;
                  cnt_d    = '0;
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rd_sel_q    <= '0;
         out_data_q  <= '0;
         out_bank_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         xor_q       <= '0;
         csum_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_sel_q    <= rd_sel_d;
         out_data_q  <= out_data_d;
         out_bank_q  <= out_bank_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
`ifdef READOUT_CHECKSUM_EN
         xor_q       <= xor_d;
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.rd_sel    = rd_sel_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_bank  = out_bank_q;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bank_readout_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bank_readout_sequencer : directed vector table plus corner-case sequences.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_bank_readout_sequencer;
   typedef struct {
      logic       rst;
      logic       start;
      logic       ready;
      logic       valid;
      logic       chk_db;
      logic [7:0] data;
      logic [1:0] bank;
      logic [1:0] sel;
      logic       busy;
      logic       done;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [7:0] mem [4];
   int         n_vec;
   int         n_bad;
   int         n_done;
   logic [7:0] got_d [$];
   logic [1:0] got_b [$];
   vec_t       vecs [$];

   bank_readout_sequencer_if #(.DATA_WIDTH(8), .NUM_BANKS(4)) bif ();

   bank_readout_sequencer #(
      .DATA_WIDTH   (8),
      .NUM_BANKS    (4),
      .SETTLE_CYCLES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb bif.rd_data = mem[bif.rd_sel];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic start, input logic ready,
                               input logic valid, input logic chk_db, input logic [7:0] data,
                               input logic [1:0] bank, input logic [1:0] sel,
                               input logic busy, input logic done);
      vec_t v;
      v.rst = rst; v.start = start; v.ready = ready; v.valid = valid; v.chk_db = chk_db;
      v.data = data; v.bank = bank; v.sel = sel; v.busy = busy; v.done = done;
      return v;
   endfunction

   task automatic wait_valid(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (bif.out_valid) return;
         step();
      end
      n_vec++;
      n_bad++;
      $display("FAIL wait_valid: timeout after %0d cycles", budget);
   endtask

   // Records every word accepted until the done pulse is observed
   task automatic collect(input int budget);
      got_d.delete();
      got_b.delete();
      n_done = 0;
      for (int c = 0; c < budget; c++) begin
         if (bif.out_valid && bif.out_ready) begin
            got_d.push_back(bif.out_data);
            got_b.push_back(bif.out_bank);
         end
         if (bif.done) begin
            n_done++;
            return;
         end
         step();
      end
      n_vec++;
      n_bad++;
      $display("FAIL collect: no done within %0d cycles", budget);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      logic [7:0] exp_words [4];
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      bif.start = 1'b0;
      bif.out_ready = 1'b0;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      step();

      // Full sweep, ready always high: words every 4 cycles, first 3 after start
      vecs.push_back(mk(1,0,1, 0,1,8'h00,2'd0,2'd0, 0,0));
      vecs.push_back(mk(0,1,1, 0,0,8'h00,2'd0,2'd0, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd0, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd0, 1,0));
      vecs.push_back(mk(0,0,1, 1,1,8'h11,2'd0,2'd0, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd1, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd1, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd1, 1,0));
      vecs.push_back(mk(0,0,1, 1,1,8'h22,2'd1,2'd1, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd2, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd2, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd2, 1,0));
      vecs.push_back(mk(0,0,1, 1,1,8'h33,2'd2,2'd2, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd3, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd3, 1,0));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd3, 1,0));
      vecs.push_back(mk(0,0,1, 1,1,8'h44,2'd3,2'd3, 1,0));
`ifdef READOUT_CHECKSUM_EN
      vecs.push_back(mk(0,0,1, 1,1,8'h44,2'd0,2'd3, 1,0));
`endif
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd0, 0,1));
      vecs.push_back(mk(0,0,1, 0,0,8'h00,2'd0,2'd0, 0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         bif.start = vecs[i].start;
         bif.out_ready = vecs[i].ready;
         step();
         ok = (bif.out_valid === vecs[i].valid) && (bif.rd_sel === vecs[i].sel) &&
              (bif.busy === vecs[i].busy) && (bif.done === vecs[i].done);
         if (vecs[i].chk_db)
            ok = ok && (bif.out_data === vecs[i].data) && (bif.out_bank === vecs[i].bank);
         n_vec++;
         if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%b d=%h b=%0d sel=%0d busy=%b done=%b expected v=%b d=%h b=%0d sel=%0d busy=%b done=%b",
                     i, bif.out_valid, bif.out_data, bif.out_bank, bif.rd_sel, bif.busy, bif.done,
                     vecs[i].valid, vecs[i].data, vecs[i].bank, vecs[i].sel, vecs[i].busy, vecs[i].done);
         end
      end
      bif.start = 1'b0;
      bif.out_ready = 1'b0;
      step();

      // Backpressure: bank 1 held for 10 cycles
      bif.start = 1'b1; step(); bif.start = 1'b0;
      wait_valid(20);
      bif.out_ready = 1'b1; step(); bif.out_ready = 1'b0;
      wait_valid(20);
      chk("bp_first_bank", {30'd0, bif.out_bank}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_hold", {bif.out_valid, bif.out_data, 6'd0, bif.rd_sel}, {1'b1, 8'h22, 6'd0, 2'd1});
      end
      bif.out_ready = 1'b1;
      collect(100);
      chk("bp_words", got_d.size(), 3);
      if (got_d.size() == 3)
         chk("bp_data", {got_d[0], got_d[1], got_d[2]}, {8'h22, 8'h33, 8'h44});
      step();

      // start pulses mid-sweep are ignored
      bif.start = 1'b1; step(); bif.start = 1'b0;
      fork
         collect(100);
         begin
            repeat (4) step();
            bif.start = 1'b1; step(); bif.start = 1'b0;
            repeat (4) step();
            bif.start = 1'b1; step(); bif.start = 1'b0;
         end
      join
      chk("busy_words", got_d.size(), 4);
      if (got_d.size() == 4)
         chk("busy_banks", {got_b[0], got_b[1], got_b[2], got_b[3]}, {2'd0, 2'd1, 2'd2, 2'd3});
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bif.busy || bif.done || bif.out_valid) ok = 1'b0;
      end
      chk("busy_no_requeue", {31'd0, ok}, 32'd1);

      // start held high: back-to-back sweeps with one idle cycle
      bif.start = 1'b1; step();
      collect(100);
      chk("held_gap_busy", {31'd0, bif.busy}, 32'd0);
      step();
      chk("held_restart_busy", {31'd0, bif.busy}, 32'd1);
      collect(100);
      bif.start = 1'b0;
      chk("held_second_words", got_d.size(), 4);
      step(); step();
      chk("held_stop_busy", {31'd0, bif.busy}, 32'd0);

      // Reset while presenting bank 2
      bif.out_ready = 1'b0;
      bif.start = 1'b1; step(); bif.start = 1'b0;
      wait_valid(20);
      bif.out_ready = 1'b1; step(); bif.out_ready = 1'b0;
      wait_valid(20);
      bif.out_ready = 1'b1; step(); bif.out_ready = 1'b0;
      wait_valid(20);
      chk("rst_at_bank", {30'd0, bif.out_bank}, 32'd2);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst_outputs", {bif.out_valid, bif.busy, bif.done, bif.rd_sel}, {1'b0, 1'b0, 1'b0, 2'd0});
      chk("rst_data", {22'd0, bif.out_data, bif.out_bank}, 32'd0);
      ok = 1'b1;
      bif.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bif.done || bif.busy) ok = 1'b0;
      end
      chk("rst_no_done", {31'd0, ok}, 32'd1);

      // Checksum pattern: XOR of the four words is zero
      mem[0] = 8'h0F; mem[1] = 8'hF0; mem[2] = 8'hAA; mem[3] = 8'h55;
      exp_words[0] = 8'h0F; exp_words[1] = 8'hF0; exp_words[2] = 8'hAA; exp_words[3] = 8'h55;
      bif.start = 1'b1; step(); bif.start = 1'b0;
      collect(100);
`ifdef READOUT_CHECKSUM_EN
      chk("csum_words", got_d.size(), 5);
      if (got_d.size() == 5)
         chk("csum_word", {22'd0, got_d[4], got_b[4]}, {22'd0, 8'h00, 2'd0});
`else
      chk("csum_words", got_d.size(), 4);
`endif
      if (got_d.size() >= 4)
         chk("csum_data", {got_d[0], got_d[1], got_d[2], got_d[3]},
             {exp_words[0], exp_words[1], exp_words[2], exp_words[3]});
      step();
      chk("csum_done_pulse", {31'd0, bif.done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
